// File: rtl/ac_actuator_ctrl_if.sv
// Request/actuator bundle between the AC controller and the actuator stage.
// The master drives the request levels and the slave drives the actuator enables and status.
interface ac_actuator_ctrl_if;
    logic       heating_req;
    logic       cooling_req;
    logic       heater_on;
    logic       compressor_on;
    logic       fan_on;
    logic       busy;
    logic       conflict;
    logic [2:0] state;

    modport master (
        output heating_req,
        output cooling_req,
        input  heater_on,
        input  compressor_on,
        input  fan_on,
        input  busy,
        input  conflict,
        input  state
    );

    modport slave (
        input  heating_req,
        input  cooling_req,
        output heater_on,
        output compressor_on,
        output fan_on,
        output busy,
        output conflict,
        output state
    );
endinterface

// File: rtl/ac_actuator_ctrl.sv
// Actuator stage: turns heat/cool request levels into heater, compressor and fan enables.
// Protects the plant with a minimum run time, a fan overrun and a restart lockout.
module ac_actuator_ctrl #(
    parameter int unsigned MIN_ON   = 8,
    parameter int unsigned FAN_POST = 4,
    parameter int unsigned LOCKOUT  = 6,
    parameter int unsigned CNT_W    = 8
) (
    input logic               clk,
    input logic               rst,
    ac_actuator_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StHeat   = 3'd1,
        StCool   = 3'd2,
        StFanRun = 3'd3,
        StLock   = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] MinOnLast = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] FanLast   = CNT_W'(FAN_POST - 1);
    localparam logic [CNT_W-1:0] LockLast  = CNT_W'(LOCKOUT - 1);
    localparam logic [CNT_W-1:0] TimerMax  = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             heat_only, cool_only;

    assign heat_only = bus.heating_req & ~bus.cooling_req;
    assign cool_only = bus.cooling_req & ~bus.heating_req;

    // A running mode only leaves once its minimum run has elapsed and the request for
    // that mode alone is gone; any mode change goes through fan overrun and lockout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (heat_only) begin
                    state_d = StHeat;
                end else if (cool_only) begin
                    state_d = StCool;
                end
            end
            StHeat: begin
                if ((timer_q >= MinOnLast) && !heat_only) begin
                    state_d = StFanRun;
                end
            end
            StCool: begin
                if ((timer_q >= MinOnLast) && !cool_only) begin
                    state_d = StFanRun;
                end
            end
            StFanRun: begin
                if (timer_q == FanLast) begin
                    state_d = StLock;
                end
            end
            StLock: begin
                if (timer_q == LockLast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Timer counts cycles spent in the current state and saturates instead of wrapping.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q != TimerMax) begin
            timer_d = timer_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        bus.heater_on     = (state_q == StHeat);
        bus.compressor_on = (state_q == StCool);
        bus.fan_on        = (state_q == StHeat) || (state_q == StCool) || (state_q == StFanRun);
        bus.busy          = (state_q != StIdle);
        bus.conflict      = bus.heating_req & bus.cooling_req;
        bus.state         = state_q;
    end

endmodule
